// File: rtl/regfile_wr_arbiter.sv
// regfile_wr_arbiter: shares the register-file write port between core writeback and an aux unit,
// tracking registers that are waiting on aux results.
module regfile_wr_arbiter #(
    parameter int XLEN = 32,
    parameter int STARVE_LIMIT = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wb_valid,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    input  logic            aux_valid,
    input  logic [4:0]      aux_rd,
    input  logic [XLEN-1:0] aux_data,
    output logic            aux_ready,
    input  logic            iss_valid,
    input  logic [4:0]      iss_rd,
    output logic            iss_ready,
    input  logic [4:0]      chk_rs1,
    input  logic [4:0]      chk_rs2,
    input  logic [4:0]      chk_rd,
    output logic            hazard,
    output logic            core_stall,
    output logic            rf_we,
    output logic [4:0]      rf_rd,
    output logic [XLEN-1:0] rf_wdata
);
    localparam logic [3:0] LIM = 4'(STARVE_LIMIT);
    logic [31:1]     busy;
    logic [3:0]      starve_cnt;
    logic [31:0]     bv;
    logic            aux_gnt, wb_gnt, iss_ok;
    logic [4:0]      sel_rd;
    logic [XLEN-1:0] sel_data;
    always_comb begin
        bv         = {busy, 1'b0};
        aux_gnt    = aux_valid && (!wb_valid || starve_cnt >= LIM);
        wb_gnt     = wb_valid && !aux_gnt;
        iss_ok     = iss_valid && !bv[iss_rd];
        sel_rd     = aux_gnt ? aux_rd : wb_gnt ? wb_rd : 5'd0;
        sel_data   = aux_gnt ? aux_data : wb_gnt ? wb_data : '0;
        aux_ready  = !rst && aux_gnt;
        iss_ready  = !rst && iss_ok;
        hazard     = !rst && (bv[chk_rs1] || bv[chk_rs2] || bv[chk_rd]);
        core_stall = !rst && wb_valid && aux_gnt;
        rf_we      = !rst && (aux_gnt || wb_gnt) && sel_rd != 5'd0;
        rf_rd      = rst ? 5'd0 : sel_rd;
        rf_wdata   = rst ? '0 : sel_data;
    end
    // A set can only target a non-busy index, so it never collides with a clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy       <= '0;
            starve_cnt <= '0;
        end else begin
            starve_cnt <= (!aux_valid || aux_gnt) ? 4'd0 : (starve_cnt >= LIM) ? LIM : starve_cnt + 4'd1;
            for (int i = 1; i < 32; i++)
                busy[i] <= (iss_ok && iss_rd == 5'(i)) || (busy[i] && !(aux_gnt && aux_rd == 5'(i)));
        end
    end
endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// tb_regfile_wr_arbiter: directed checks of arbitration, scoreboard and starvation bound.
module tb_regfile_wr_arbiter;
    logic        clk = 0, rst = 1;
    logic        wb_valid = 0, aux_valid = 0, iss_valid = 0;
    logic [4:0]  wb_rd = 0, aux_rd = 0, iss_rd = 0, chk_rs1 = 0, chk_rs2 = 0, chk_rd = 0;
    logic [31:0] wb_data = 0, aux_data = 0;
    logic        aux_ready, iss_ready, hazard, core_stall, rf_we;
    logic [4:0]  rf_rd;
    logic [31:0] rf_wdata;
    int vectors = 0, errs = 0;

    regfile_wr_arbiter #(.XLEN(32), .STARVE_LIMIT(3)) dut (
        .clk(clk), .rst(rst), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .aux_valid(aux_valid), .aux_rd(aux_rd), .aux_data(aux_data), .aux_ready(aux_ready),
        .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_ready(iss_ready),
        .chk_rs1(chk_rs1), .chk_rs2(chk_rs2), .chk_rd(chk_rd), .hazard(hazard),
        .core_stall(core_stall), .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic nx;
        @(posedge clk);
        #1;
    endtask

    task automatic smp;
        @(negedge clk);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_aux_ready"}, 32'(aux_ready), 0);
        chk({tag, "_iss_ready"}, 32'(iss_ready), 0);
        chk({tag, "_hazard"}, 32'(hazard), 0);
        chk({tag, "_core_stall"}, 32'(core_stall), 0);
        chk({tag, "_rf_we"}, 32'(rf_we), 0);
        chk({tag, "_rf_rd"}, 32'(rf_rd), 0);
        chk({tag, "_rf_wdata"}, rf_wdata, 0);
    endtask

    initial begin
        nx; rst = 1; wb_valid = 1; wb_rd = 7; wb_data = 32'h1111; aux_valid = 1; aux_rd = 4;
        aux_data = 32'h2222; iss_valid = 1; iss_rd = 2;
        smp; chk_all_zero("rst0");
        nx; smp; chk_all_zero("rst1");

        nx; rst = 0; wb_valid = 0; aux_valid = 0; iss_valid = 0; chk_rs1 = 5;
        smp; chk("post_rst_hazard", 32'(hazard), 0); chk("post_rst_we", 32'(rf_we), 0);

        nx; wb_valid = 1; wb_rd = 7; wb_data = 32'hDEADBEEF;
        smp; chk("core_we", 32'(rf_we), 1); chk("core_rd", 32'(rf_rd), 7);
        chk("core_wdata", rf_wdata, 32'hDEADBEEF); chk("core_stall", 32'(core_stall), 0);
        chk("core_aux_ready", 32'(aux_ready), 0);

        nx; wb_rd = 0;
        smp; chk("core_x0_we", 32'(rf_we), 0);

        nx; wb_valid = 0; iss_valid = 1; iss_rd = 9; chk_rs2 = 9;
        smp; chk("iss9_ready", 32'(iss_ready), 1); chk("iss9_no_bypass", 32'(hazard), 0);

        nx;
        smp; chk("iss9_again_ready", 32'(iss_ready), 0); chk("hazard9", 32'(hazard), 1);

        nx; iss_valid = 0; aux_valid = 1; aux_rd = 9; aux_data = 32'h1234;
        smp; chk("aux9_ready", 32'(aux_ready), 1); chk("aux9_we", 32'(rf_we), 1);
        chk("aux9_rd", 32'(rf_rd), 9); chk("aux9_wdata", rf_wdata, 32'h1234);
        chk("aux9_hazard_cur", 32'(hazard), 1);

        nx; aux_valid = 0;
        smp; chk("aux9_cleared", 32'(hazard), 0);

        nx; wb_valid = 1; wb_rd = 5; wb_data = 32'hAAAA; aux_valid = 1; aux_rd = 17; aux_data = 32'hBBBB;
        for (int c = 0; c < 3; c++) begin
            if (c > 0) nx;
            smp; chk($sformatf("starve%0d_aux_ready", c), 32'(aux_ready), 0);
            chk($sformatf("starve%0d_rd", c), 32'(rf_rd), 5);
            chk($sformatf("starve%0d_stall", c), 32'(core_stall), 0);
        end
        nx; smp; chk("starve3_aux_ready", 32'(aux_ready), 1); chk("starve3_stall", 32'(core_stall), 1);
        chk("starve3_rd", 32'(rf_rd), 17); chk("starve3_wdata", rf_wdata, 32'hBBBB);
        nx; smp; chk("starve4_aux_ready", 32'(aux_ready), 0); chk("starve4_rd", 32'(rf_rd), 5);
        chk("starve4_stall", 32'(core_stall), 0);

        nx; wb_valid = 0; aux_valid = 0; iss_valid = 1; iss_rd = 20; chk_rs2 = 0;
        smp; chk("iss20_ready", 32'(iss_ready), 1);
        nx; iss_valid = 0; aux_valid = 1; aux_rd = 0; aux_data = 32'h5555;
        smp; chk("aux_x0_ready", 32'(aux_ready), 1); chk("aux_x0_we", 32'(rf_we), 0);
        nx; aux_valid = 0; chk_rd = 20;
        smp; chk("x0_busy_kept", 32'(hazard), 1);

        nx; iss_valid = 1; iss_rd = 3;
        smp; chk("iss3_ready", 32'(iss_ready), 1);
        nx; iss_rd = 12;
        smp; chk("iss12_ready", 32'(iss_ready), 1);
        nx; iss_valid = 0; chk_rs1 = 3; chk_rs2 = 12; chk_rd = 0;
        smp; chk("busy3_12_hazard", 32'(hazard), 1);
        nx; rst = 1;
        smp; chk("mid_rst_hazard", 32'(hazard), 0);
        nx; rst = 0; iss_valid = 1; iss_rd = 3;
        smp; chk("after_rst_hazard", 32'(hazard), 0); chk("after_rst_iss3", 32'(iss_ready), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
